// File: rtl/encoder_8_to_3_seq_pkg.sv
// Shared encoder/decoder definitions: line count, index width, FSM states,
// and the index-to-line helper used when clearing served lines.
package enc_dec_pkg;

   localparam int unsigned LINES = 8;
   localparam int unsigned IDX_W = 3;

   typedef enum logic {IDLE, EMIT} enc_state_t;

   function automatic logic [LINES-1:0] onehot(input logic [IDX_W-1:0] idx);
      return LINES'(1) << idx;
   endfunction

endpackage

// File: rtl/encoder_8_to_3_seq_if.sv
// Capture/emit handshake bundle between a line-vector producer and the encoder.
interface encoder_8_to_3_seq_if;
   import enc_dec_pkg::*;

   logic             E;
   logic [LINES-1:0] D;
   logic             in_valid;
   logic             in_ready;
   logic [IDX_W-1:0] A;
   logic             out_valid;
   logic             out_ready;
   logic             last;
   logic             zero;

   modport master (
      output E, D, in_valid, out_ready,
      input  in_ready, A, out_valid, last, zero
   );

   modport slave (
      input  E, D, in_valid, out_ready,
      output in_ready, A, out_valid, last, zero
   );

endinterface

// File: rtl/encoder_8_to_3_seq_pri_enc.sv
// Combinational 8-to-3 priority encoder with selectable search direction.
module pri_enc_8_to_3
   import enc_dec_pkg::*;
(
   input  logic [LINES-1:0] vec,
   input  logic             msb_first,
   output logic [IDX_W-1:0] idx,
   output logic             any,
   output logic             single
);

   always_comb begin
      idx    = '0;
      any    = |vec;
      single = any && ((vec & (vec - LINES'(1))) == '0);
      // Later loop iterations override earlier ones, so scan toward the winner.
      if (msb_first) begin
         for (int unsigned i = 0; i < LINES; i++) begin
            if (vec[i]) idx = IDX_W'(i);
         end
      end else begin
         for (int unsigned i = 0; i < LINES; i++) begin
            if (vec[LINES-1-i]) idx = IDX_W'(LINES - 1 - i);
         end
      end
   end

endmodule

// File: rtl/encoder_8_to_3_seq.sv
// Sequential priority encoder: captures a line vector, then emits the index of
// every set line, one per accepted beat, clearing each line as it is served.
module encoder_8_to_3_seq
   import enc_dec_pkg::*;
#(
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   encoder_8_to_3_seq_if.slave  bus
);

   enc_state_t       r_state;
   logic [LINES-1:0] r_pending;
   logic             r_zero;

   logic [IDX_W-1:0] w_idx;
   logic             w_any;
   logic             w_single;
   logic             w_last;
   logic             w_in_ready;

   pri_enc_8_to_3 u_pri_enc (
      .vec       (r_pending),
      .msb_first (MSB_FIRST),
      .idx       (w_idx),
      .any       (w_any),
      .single    (w_single)
   );

   assign w_last     = r_zero | w_single;
   assign w_in_ready = bus.E & (r_state == IDLE) & rst_n;

   // Outputs decode only registered state; out_ready never reaches them.
   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = (r_state == EMIT);
   assign bus.A         = ((r_state == EMIT) && w_any) ? w_idx : '0;
   assign bus.last      = (r_state == EMIT) & w_last;
   assign bus.zero      = (r_state == EMIT) & r_zero;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_pending <= '0;
         r_zero    <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.in_valid && w_in_ready) begin
                  r_pending <= bus.D;
                  r_zero    <= (bus.D == '0);
                  r_state   <= EMIT;
               end
            end
            EMIT: begin
               if (bus.out_ready) begin
                  r_pending <= r_pending & ~onehot(w_idx);
                  if (w_last) begin
                     r_zero  <= 1'b0;
                     r_state <= IDLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
